// File: rtl/des_iter_if.sv
// Block/key input and result output handshake bundle for the iterative DES
// sequencer. The controller is the slave; whoever feeds blocks and takes
// results is the master.
interface des_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [63:0] in_text;
    logic [63:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_text;

    modport slave (
        input  in_valid, in_mode, in_text, in_key, out_ready,
        output in_ready, out_valid, out_text
    );

    modport master (
        output in_valid, in_mode, in_text, in_key, out_ready,
        input  in_ready, out_valid, out_text
    );
endinterface

// File: rtl/des_iter_ctrl.sv
// Iterative DES round sequencer. Takes an initially-permuted block and a key,
// hands the key to the combinational key schedule, then drives a single
// external Feistel round unit for ROUNDS cycles, selecting the round key in
// forward order for encrypt and reverse order for decrypt. The swapped
// {R16,L16} result is held until the consumer accepts it.
module des_iter_ctrl #(
    parameter int ROUNDS = 16,
    parameter int IDX_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    des_iter_if.slave              bus,
    output logic [63:0]            key_o,
    input  logic [48*ROUNDS-1:0]   round_keys_i,
    output logic [63:0]            round_state_o,
    output logic [47:0]            round_key_o,
    input  logic [63:0]            round_state_i,
    output logic                   busy,
    output logic [IDX_W-1:0]       round_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q,   cnt_d;
    logic [63:0]        blk_q,   blk_d;
    logic [63:0]        key_q,   key_d;
    logic               mode_q,  mode_d;
    logic [IDX_W-1:0]   key_idx;

    // Control and datapath registers; reset clears everything so an
    // abandoned block leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic: capture on accept, one round per RUN cycle, hold the
    // result in DONE until the consumer takes it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        key_d   = key_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    blk_d   = bus.in_text;
                    key_d   = bus.in_key;
                    mode_d  = bus.in_mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                blk_d = round_state_i;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Round key selection: decrypt walks the schedule backwards.
    always_comb begin
        key_idx     = mode_q ? (LAST - cnt_q) : cnt_q;
        round_key_o = round_keys_i[48*int'(key_idx) +: 48];
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    // Undo the last round's half swap before the final permutation.
    assign bus.out_text  = {blk_q[31:0], blk_q[63:32]};

    assign key_o         = key_q;
    assign round_state_o = blk_q;
    assign busy          = (state_q != IDLE);
    assign round_idx     = cnt_q;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Bench for des_iter_ctrl: attaches a behavioural key schedule and round unit,
// applies the FIPS DES vector in both directions and exercises backpressure,
// back-to-back blocks and reset.
module tb_des_iter_ctrl;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;

    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{
        32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{
        57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2,
        59,51,43,35,27,19,11,3, 60,52,44,36,63,55,47,39,
        31,23,15,7,62,54,46,38, 30,22,14,6,61,53,45,37,
        29,21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [63:0] des_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  b;
        int          row, col, v;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            b   = e[47-6*j -: 6];
            row = int'({b[5], b[0]});
            col = int'(b[4:1]);
            v   = SBOX[j][row*16+col];
            s[31-4*j -: 4] = 4'(v);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    function automatic logic [767:0] des_ks(input logic [63:0] key);
        logic [55:0]  cd;
        logic [27:0]  c, d;
        logic [47:0]  k;
        logic [767:0] ks;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SH_T[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
            ks[48*r +: 48] = k;
        end
        return ks;
    endfunction

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  key_o;
    logic [767:0] round_keys_i;
    logic [63:0]  round_state_o;
    logic [47:0]  round_key_o;
    logic [63:0]  round_state_i;
    logic         busy;
    logic [3:0]   round_idx;

    des_iter_if bus();

    des_iter_ctrl #(.ROUNDS(16), .IDX_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .key_o         (key_o),
        .round_keys_i  (round_keys_i),
        .round_state_o (round_state_o),
        .round_key_o   (round_key_o),
        .round_state_i (round_state_i),
        .busy          (busy),
        .round_idx     (round_idx)
    );

    // Behavioural key schedule and single Feistel round attached to the DUT.
    assign round_keys_i  = des_ks(key_o);
    assign round_state_i = {round_state_o[31:0],
                            round_state_o[63:32] ^ des_f(round_state_o[31:0], round_key_o)};

    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("out_valid_seen", 64'(bus.out_valid), 64'd1);
    endtask

    logic [767:0] ks_ref;
    logic [63:0]  held;
    logic [63:0]  a_out;
    logic         rdy;
    int           n;
    int           acc;

    initial begin
        ks_ref        = des_ks(KEY);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_text   = des_ip(PT);
        bus.in_key    = KEY;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;
        a_out         = '0;

        // Reset held with a block offered: nothing may be accepted.
        repeat (3) begin
            tick();
            chk("rst_busy", 64'(busy), 64'd0);
        end
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_idx", 64'(round_idx), 64'd0);
        chk("rst_state", round_state_o, 64'd0);
        chk("rst_key", key_o, 64'd0);

        // First edge with rst low accepts the encrypt block.
        rst = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("acc_busy", 64'(busy), 64'd1);
        chk("acc_in_ready", 64'(bus.in_ready), 64'd0);
        chk("acc_key", key_o, KEY);
        chk("acc_state", round_state_o, des_ip(PT));
        chk("acc_idx", 64'(round_idx), 64'd0);
        wait_valid(n);
        // Counting the cycle that starts at the accept edge as cycle 1.
        chk("enc_latency", 64'(n + 1), 64'd17);
        chk("enc_ct", des_fp(bus.out_text), CT);
        tick();
        chk("enc_exit_valid", 64'(bus.out_valid), 64'd0);
        chk("enc_exit_busy", 64'(busy), 64'd0);
        chk("enc_exit_idx", 64'(round_idx), 64'd0);
        chk("enc_exit_rdy", 64'(bus.in_ready), 64'd1);

        // Decrypt: round keys consumed in reverse order.
        bus.in_valid = 1'b1;
        bus.in_text  = des_ip(CT);
        bus.in_mode  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("dec_idx", 64'(round_idx), 64'(i));
            chk("dec_key", 64'(round_key_o), 64'(ks_ref[48*(15-i) +: 48]));
            tick();
        end
        chk("dec_valid", 64'(bus.out_valid), 64'd1);
        chk("dec_pt", des_fp(bus.out_text), PT);
        tick();

        // Backpressure: result held, second block offered and refused.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_text   = des_ip(PT);
        bus.in_mode   = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(n);
        held = bus.out_text;
        chk("bp_ct", des_fp(held), CT);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                bus.in_valid = 1'b1;
                bus.in_text  = des_ip(CT);
                bus.in_mode  = 1'b1;
            end
            if (c == 6) bus.in_valid = 1'b0;
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_text", bus.out_text, held);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        chk("bp_still_ct", des_fp(bus.out_text), CT);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_exit_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_exit_busy", 64'(busy), 64'd0);

        // Back-to-back: A encrypt then B decrypt with in_valid held high.
        bus.in_valid = 1'b1;
        bus.in_text  = des_ip(PT);
        bus.in_mode  = 1'b0;
        tick();
        bus.in_text  = des_ip(CT);
        bus.in_mode  = 1'b1;
        acc = 0;
        for (int k = 1; k <= 40 && acc == 0; k++) begin
            rdy = bus.in_ready;
            if (bus.out_valid) a_out = bus.out_text;
            tick();
            if (rdy) acc = k;
        end
        bus.in_valid = 1'b0;
        chk("b2b_interval", 64'(acc), 64'd18);
        chk("b2b_a_ct", des_fp(a_out), CT);
        wait_valid(n);
        chk("b2b_b_pt", des_fp(bus.out_text), PT);
        tick();

        // Reset in the middle of a block.
        bus.in_valid = 1'b1;
        bus.in_text  = des_ip(PT);
        bus.in_mode  = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        chk("mid_idx_before", 64'(round_idx), 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_idx", 64'(round_idx), 64'd0);
        repeat (20) tick();
        chk("mid_no_output", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(n);
        chk("mid_after_ct", des_fp(bus.out_text), CT);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
